// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake, pass-through tag and registered flags.
// Define ALU_FLAGS_EXT_EN to add the out_neg / out_ovf flag outputs.
module alu_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_carry,
  output logic [TAG_W-1:0] out_tag
`ifdef ALU_FLAGS_EXT_EN
  ,
  output logic             out_neg,
  output logic             out_ovf
`endif
);

  localparam int unsigned W1 = WIDTH + 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;

  logic s2_free;
  logic s1_move;
  logic in_fire;

  // S1 may advance whenever S2 is empty or handing its result downstream this cycle.
  assign s2_free  = !out_valid || out_ready;
  assign s1_move  = s1_valid && s2_free;
  assign in_ready = rst_n && (!s1_valid || s1_move);
  assign in_fire  = in_valid && in_ready;

  logic [W1-1:0]    sum_x;
  logic [W1-1:0]    dif_x;
  logic [W1-1:0]    shl_x;
  logic [W1-1:0]    shr_x;
  logic [WIDTH-1:0] res_data;
  logic             res_carry;

  // Shifts run one bit wider so the last bit shifted out lands in the extra bit;
  // amounts beyond WIDTH naturally clear both data and carry.
  always_comb begin
    sum_x     = {1'b0, s1_a} + {1'b0, s1_b};
    dif_x     = {1'b0, s1_a} - {1'b0, s1_b};
    shl_x     = {1'b0, s1_a} << s1_b;
    shr_x     = {s1_a, 1'b0} >> s1_b;
    res_data  = '0;
    res_carry = 1'b0;
    case (s1_op)
      OP_ADD:  begin res_data = sum_x[WIDTH-1:0]; res_carry = sum_x[WIDTH]; end
      OP_SUB:  begin res_data = dif_x[WIDTH-1:0]; res_carry = dif_x[WIDTH]; end
      OP_AND:  res_data = s1_a & s1_b;
      OP_OR:   res_data = s1_a | s1_b;
      OP_XOR:  res_data = s1_a ^ s1_b;
      OP_XNOR: res_data = ~(s1_a ^ s1_b);
      OP_SHL:  begin res_data = shl_x[WIDTH-1:0]; res_carry = shl_x[WIDTH]; end
      OP_SHR:  begin res_data = shr_x[W1-1:1]; res_carry = shr_x[0]; end
      default: ;
    endcase
  end

`ifdef ALU_FLAGS_EXT_EN
  logic res_ovf;

  // Two's-complement overflow: operand signs vs. result sign.
  always_comb begin
    res_ovf = 1'b0;
    case (s1_op)
      OP_ADD:  res_ovf = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum_x[WIDTH-1] != s1_a[WIDTH-1]);
      OP_SUB:  res_ovf = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (dif_x[WIDTH-1] != s1_a[WIDTH-1]);
      default: res_ovf = 1'b0;
    endcase
  end
`endif

  // Stage 1: operand capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_tag   <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_op    <= in_op;
      s1_tag   <= in_tag;
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: result register, held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_zero  <= 1'b0;
      out_carry <= 1'b0;
      out_tag   <= '0;
`ifdef ALU_FLAGS_EXT_EN
      out_neg   <= 1'b0;
      out_ovf   <= 1'b0;
`endif
    end else if (s1_move) begin
      out_valid <= 1'b1;
      out_data  <= res_data;
      out_zero  <= (res_data == '0);
      out_carry <= res_carry;
      out_tag   <= s1_tag;
`ifdef ALU_FLAGS_EXT_EN
      out_neg   <= res_data[WIDTH-1];
      out_ovf   <= res_ovf;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: random and directed ops against an arithmetic reference model,
// with random output backpressure and a mid-stream reset.
module tb_alu_pipe;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned TAG_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_carry;
  logic [TAG_W-1:0] out_tag;
`ifdef ALU_FLAGS_EXT_EN
  logic             out_neg;
  logic             out_ovf;
`endif

  alu_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .out_carry(out_carry), .out_tag(out_tag)
`ifdef ALU_FLAGS_EXT_EN
    , .out_neg(out_neg), .out_ovf(out_ovf)
`endif
  );

  typedef struct packed {
    logic [7:0] data;
    logic       zero;
    logic       carry;
    logic       neg;
    logic       ovf;
    logic [3:0] tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   rdy_mode = 1;

  logic       prev_stall = 1'b0;
  logic [7:0] pd;
  logic       pz, pc;
  logic [3:0] pt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on 8-bit values.
  function automatic exp_t model(int a, int b, int op, int tag);
    exp_t m;
    int r, c, ov, sa, sb, sr;
    c  = 0;
    ov = 0;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (op)
      0: begin r = a + b; c = (r > 255) ? 1 : 0; sr = sa + sb; ov = (sr > 127 || sr < -128) ? 1 : 0; end
      1: begin r = a - b; c = (a < b) ? 1 : 0;   sr = sa - sb; ov = (sr > 127 || sr < -128) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~(a ^ b);
      6: begin
        if (b == 0) r = a;
        else if (b <= 8) begin r = a << b; c = (a >> (8 - b)) & 1; end
        else r = 0;
      end
      default: begin
        if (b == 0) r = a;
        else if (b <= 8) begin r = a >> b; c = (a >> (b - 1)) & 1; end
        else r = 0;
      end
    endcase
    r       = r & 255;
    m.data  = 8'(r);
    m.zero  = (r == 0);
    m.carry = (c != 0);
    m.neg   = (r >= 128);
    m.ovf   = (ov != 0);
    m.tag   = 4'(tag);
    return m;
  endfunction

  task automatic check(string name, logic ok, string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  // Present one op from posedge+1 until accepted; expected result enters the scoreboard on accept.
  task automatic issue(int a, int b, int op, int tag);
    int waited = 0;
    in_valid = 1'b1;
    in_a     = 8'(a);
    in_b     = 8'(b);
    in_op    = 3'(op);
    in_tag   = 4'(tag);
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 1'b0, $sformatf("in_ready=%b want 1 within 200 cycles", in_ready));
    else exp_q.push_back(model(a, b, op, tag));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    rdy_mode = 1;
    while (exp_q.size() != 0 && waited < 300) begin
      waited++;
      @(negedge clk);
    end
    check("drain", exp_q.size() == 0, $sformatf("pending=%0d want 0", exp_q.size()));
  endtask

  task automatic rand_ops(int n, int tag0);
    int b;
    for (int i = 0; i < n; i++) begin
      b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 10));
      issue(int'($urandom_range(0, 255)), b, int'($urandom_range(0, 7)), (tag0 + i) & 15);
    end
  endtask

  // Output backpressure driver.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: stall stability and in-order scoreboard compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", out_valid && out_data == pd && out_zero == pz && out_carry == pc && out_tag == pt,
              $sformatf("got v=%b d=%h z=%b c=%b t=%h want v=1 d=%h z=%b c=%b t=%h",
                        out_valid, out_data, out_zero, out_carry, out_tag, pd, pz, pc, pt));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1'b0, $sformatf("got d=%h t=%h want no output", out_data, out_tag));
        end else begin
          e = exp_q.pop_front();
`ifdef ALU_FLAGS_EXT_EN
          check("result", out_data == e.data && out_zero == e.zero && out_carry == e.carry &&
                          out_tag == e.tag && out_neg == e.neg && out_ovf == e.ovf,
                $sformatf("got d=%h z=%b c=%b t=%h n=%b o=%b want d=%h z=%b c=%b t=%h n=%b o=%b",
                          out_data, out_zero, out_carry, out_tag, out_neg, out_ovf,
                          e.data, e.zero, e.carry, e.tag, e.neg, e.ovf));
`else
          check("result", out_data == e.data && out_zero == e.zero && out_carry == e.carry && out_tag == e.tag,
                $sformatf("got d=%h z=%b c=%b t=%h want d=%h z=%b c=%b t=%h",
                          out_data, out_zero, out_carry, out_tag, e.data, e.zero, e.carry, e.tag));
`endif
        end
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data;
      pz = out_zero;
      pc = out_carry;
      pt = out_tag;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // op, a, b
  int dv[15][3] = '{
    '{1, 8'h0A, 8'h0A}, '{1, 8'h03, 8'h05}, '{0, 8'hFF, 8'h01}, '{0, 8'h7F, 8'h01},
    '{2, 8'hAA, 8'hF0}, '{3, 8'hAA, 8'hF5}, '{4, 8'h56, 8'h5C}, '{5, 8'hAA, 8'hF0},
    '{6, 8'hAA, 1},     '{7, 8'hAA, 1},     '{6, 8'hAA, 9},     '{7, 8'hAA, 8},
    '{6, 8'h81, 8},     '{7, 8'hAA, 200},   '{6, 8'h3C, 0}
  };

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_op    = '0;
    in_tag   = '0;
    repeat (3) @(negedge clk);
    check("reset_state", !in_ready && !out_valid && out_data == 8'h00 && !out_zero && !out_carry && out_tag == 4'h0,
          $sformatf("got rdy=%b v=%b d=%h z=%b c=%b t=%h want all 0",
                    in_ready, out_valid, out_data, out_zero, out_carry, out_tag));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", in_ready == 1'b1, $sformatf("got %b want 1", in_ready));

    // Latency: accept in cycle t, result visible in cycle t+2.
    @(posedge clk);
    #1;
    issue(8, 5, 0, 1);
    @(negedge clk);
    check("latency_t1", out_valid == 1'b0, $sformatf("out_valid=%b want 0", out_valid));
    @(negedge clk);
    check("latency_t2", out_valid == 1'b1, $sformatf("out_valid=%b want 1", out_valid));
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) issue(dv[i][1], dv[i][2], dv[i][0], i);
    drain();

    // 16 back-to-back ops under random backpressure, tags 0..15.
    @(posedge clk);
    #1;
    rdy_mode = 2;
    rand_ops(16, 0);
    drain();

    // Stall the output, fill both stages, then reset mid-stream.
    @(posedge clk);
    #2;
    rdy_mode = 0;
    issue(8'h11, 8'h22, 0, 5);
    issue(8'h40, 8'h01, 6, 6);
    @(negedge clk);
    check("backpressure_in_ready", in_ready == 1'b0, $sformatf("in_ready=%b want 0", in_ready));
    check("stalled_tag", out_valid && out_tag == 4'h5 && out_data == 8'h33,
          $sformatf("got v=%b t=%h d=%h want v=1 t=5 d=33", out_valid, out_tag, out_data));
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("reset_mid_stream", !out_valid && !in_ready && out_data == 8'h00 && out_tag == 4'h0 && !out_carry && !out_zero,
          $sformatf("got v=%b rdy=%b d=%h t=%h c=%b z=%b want all 0",
                    out_valid, in_ready, out_data, out_tag, out_carry, out_zero));
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rdy_mode = 2;
    @(negedge clk);
    check("post_reset_clean", in_ready && !out_valid, $sformatf("got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid));
    repeat (3) @(negedge clk);
    check("no_stale_result", !out_valid, $sformatf("out_valid=%b want 0", out_valid));

    @(posedge clk);
    #1;
    rand_ops(40, 3);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
